// File: rtl/cl_pkg.sv
// Shared constants for the cache-line frame path: line/head geometry and head bit positions,
// plus the frame-tracking state type used by the optional head checker.
package cl_pkg;

    localparam int CL           = 512;
    localparam int CL_HEAD      = 16;
    localparam int CL_PAYLOAD   = CL - CL_HEAD;
    localparam int ST           = 12;
    localparam int w_len_CLHead = 10;
    localparam int SOF_BIT      = 14;
    localparam int EOF_BIT      = 15;
    localparam int MAX_SYM      = 41;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_OPEN = 1'b1
    } frame_state_e;

    // Symbol count outside 1..MAX_SYM cannot describe a real payload.
    function automatic logic len_illegal(input logic [w_len_CLHead-1:0] len);
        return (len == '0) || (len > w_len_CLHead'(MAX_SYM));
    endfunction

endpackage

// File: rtl/cl_frame_buffer_if.sv
// Host-write / converter-read bus of the frame buffer. The master is the surrounding logic
// (host writer plus CL2st converter); the slave is the buffer itself.
interface cl_frame_buffer_if;
    import cl_pkg::*;

    logic          wr_valid;
    logic          wr_ready;
    logic [CL-1:0] wr_data;
    logic          ff_rd_ready;
    logic          ff_rdreq;
    logic [CL-1:0] ff_q;
    logic          ff_empty;

    modport master (
        output wr_valid, wr_data, ff_rdreq,
        input  wr_ready, ff_rd_ready, ff_q, ff_empty
    );

    modport slave (
        input  wr_valid, wr_data, ff_rdreq,
        output wr_ready, ff_rd_ready, ff_q, ff_empty
    );

endinterface

// File: rtl/cl_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on o_rd_data, a pop moves to
// the next one. Callers gate i_wr_en / i_rd_en against full / empty.
module cl_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // NOTE: the storage array is deliberately not reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;

endmodule

// File: rtl/cl_frame_buffer.sv
// Cache-line frame buffer ahead of CL2st_preAFU: stores host lines and counts complete frames.
// Define CL_FRAME_BUF_CHECK_EN to compile in the sticky head/sequence checker.
module cl_frame_buffer
    import cl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    cl_frame_buffer_if.slave    bus,
    output logic [AW:0]         fill_level,
    output logic [AW:0]         frame_cnt,
    output logic                err_len,
    output logic                err_seq,
    output logic                err_ovf,
    output logic                err_udf
);

    logic          r_init_done;
    logic [AW:0]   r_frame_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_push_eof;
    logic          w_pop_eof;
    logic [CL-1:0] w_q;

    // Holds wr_ready low through reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_init_done <= 1'b0;
        else        r_init_done <= 1'b1;
    end

    assign bus.wr_ready = r_init_done & ~w_full;
    assign w_push       = bus.wr_valid & bus.wr_ready;
    assign w_pop        = bus.ff_rdreq & ~w_empty;

    cl_sync_fifo #(
        .WIDTH (CL),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_push),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_q),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (fill_level)
    );

    assign bus.ff_q     = w_q;
    assign bus.ff_empty = w_empty;

    assign w_push_eof = w_push & bus.wr_data[EOF_BIT];
    assign w_pop_eof  = w_pop  & w_q[EOF_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else begin
            case ({w_push_eof, w_pop_eof})
                2'b10:   r_frame_cnt <= r_frame_cnt + 1'b1;
                2'b01:   r_frame_cnt <= r_frame_cnt - 1'b1;
                default: r_frame_cnt <= r_frame_cnt;
            endcase
        end
    end

    assign frame_cnt       = r_frame_cnt;
    assign bus.ff_rd_ready = (r_frame_cnt != '0);

`ifdef CL_FRAME_BUF_CHECK_EN
    frame_state_e               r_state;
    frame_state_e               w_state_nxt;
    logic [AW:0]                r_open_lines;
    logic [AW:0]                w_open_lines_nxt;
    logic [w_len_CLHead-1:0]    w_len;
    logic                       w_sof;
    logic                       w_eof;
    logic                       w_seq_bad;
    logic                       w_ovf_hit;
    logic                       r_err_len;
    logic                       r_err_seq;
    logic                       r_err_ovf;
    logic                       r_err_udf;

    assign w_len = bus.wr_data[w_len_CLHead-1:0];
    assign w_sof = bus.wr_data[SOF_BIT];
    assign w_eof = bus.wr_data[EOF_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FR_IDLE;
            r_open_lines <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_open_lines <= w_open_lines_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_open_lines_nxt = r_open_lines;
        w_seq_bad        = 1'b0;
        w_ovf_hit        = 1'b0;
        if (w_push) begin
            w_seq_bad = w_sof ? (r_state == FR_OPEN) : (r_state == FR_IDLE);
            if (w_eof) begin
                w_state_nxt      = FR_IDLE;
                w_open_lines_nxt = '0;
            end else begin
                w_state_nxt = FR_OPEN;
                if (w_sof || r_state == FR_IDLE)
                    w_open_lines_nxt = (AW+1)'(1);
                else if (r_open_lines != (AW+1)'(DEPTH))
                    w_open_lines_nxt = r_open_lines + 1'b1;
                w_ovf_hit = (w_open_lines_nxt == (AW+1)'(DEPTH));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_len <= 1'b0;
            r_err_seq <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_push && len_illegal(w_len))  r_err_len <= 1'b1;
            if (w_seq_bad)                     r_err_seq <= 1'b1;
            if (w_ovf_hit)                     r_err_ovf <= 1'b1;
            if (bus.ff_rdreq && w_empty)       r_err_udf <= 1'b1;
        end
    end

    assign err_len = r_err_len;
    assign err_seq = r_err_seq;
    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    assign err_len = 1'b0;
    assign err_seq = 1'b0;
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_cl_frame_buffer.sv
// Randomized bench for cl_frame_buffer against a queue-based model of the buffered lines.
// Error-flag expectations are modelled only when CL_FRAME_BUF_CHECK_EN is defined.
module tb_cl_frame_buffer;
    import cl_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [AW:0] fill_level;
    logic [AW:0] frame_cnt;
    logic        err_len, err_seq, err_ovf, err_udf;

    always #5 clk = ~clk;

    cl_frame_buffer_if bus();

    cl_frame_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fill_level (fill_level),
        .frame_cnt  (frame_cnt),
        .err_len    (err_len),
        .err_seq    (err_seq),
        .err_ovf    (err_ovf),
        .err_udf    (err_udf)
    );

    // Reference model: the buffer content as an ordered list of lines.
    logic [CL-1:0] q[$];
    bit            ready_en;
    bit            last_acc;
    bit            exp_len, exp_seq, exp_ovf, exp_udf;
    bit            m_open;
    int            m_lines;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eof_lines();
        int n = 0;
        foreach (q[i]) if (q[i][EOF_BIT]) n++;
        return n;
    endfunction

    function automatic logic [CL-1:0] make_line(input bit sof, input bit eof, input int len);
        logic [CL-1:0] l;
        for (int i = 0; i < CL/32; i++) l[i*32 +: 32] = $urandom;
        l[15:0] = {eof, sof, 4'b0000, 10'(len)};
        return l;
    endfunction

    task automatic check_outputs();
        check("wr_ready",    bus.wr_ready,    ready_en && q.size() != DEPTH);
        check("ff_empty",    bus.ff_empty,    q.size() == 0);
        check("fill_level",  fill_level,      q.size());
        check("frame_cnt",   frame_cnt,       eof_lines());
        check("ff_rd_ready", bus.ff_rd_ready, eof_lines() != 0);
        if (q.size() != 0) check("ff_q", bus.ff_q, q[0]);
        check("err_len", err_len, exp_len);
        check("err_seq", err_seq, exp_seq);
        check("err_ovf", err_ovf, exp_ovf);
        check("err_udf", err_udf, exp_udf);
    endtask

    // One clock: drive inputs, advance the model by the documented rules, compare after the edge.
    task automatic cycle(input bit valid, input logic [CL-1:0] data, input bit rdreq);
        bit acc, rd;
        bus.wr_valid = valid;
        bus.wr_data  = data;
        bus.ff_rdreq = rdreq;
        acc = valid && ready_en && q.size() != DEPTH;
        rd  = rdreq && q.size() != 0;
`ifdef CL_FRAME_BUF_CHECK_EN
        if (rdreq && q.size() == 0) exp_udf = 1;
        if (acc) begin
            if (data[9:0] == 0 || data[9:0] > MAX_SYM) exp_len = 1;
            if (data[SOF_BIT] == m_open) exp_seq = 1;
            if (data[EOF_BIT]) begin
                m_open  = 0;
                m_lines = 0;
            end else begin
                m_lines = (data[SOF_BIT] || !m_open) ? 1 : m_lines + 1;
                m_open  = 1;
                if (m_lines >= DEPTH) exp_ovf = 1;
            end
        end
`endif
        @(posedge clk);
        #1;
        ready_en = 1;
        if (rd)  void'(q.pop_front());
        if (acc) q.push_back(data);
        last_acc     = acc;
        bus.wr_valid = 0;
        bus.ff_rdreq = 0;
        check_outputs();
    endtask

    task automatic drain();
        while (q.size() != 0) cycle(0, '0, 1);
    endtask

    initial begin
        int sent;
        int budget;
        bus.wr_valid = 0;
        bus.wr_data  = '0;
        bus.ff_rdreq = 0;

        // Reset state, including wr_ready held low until one edge after release
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        #1;
        check("wr_ready_post_rel", bus.wr_ready, 1'b0);
        cycle(0, '0, 0);
        check("wr_ready_first_edge", bus.wr_ready, 1'b1);

        // Three-line frame: ready only after the EOF line lands
        cycle(1, make_line(1, 0, 41), 0);
        check("f3_rdy_l1", bus.ff_rd_ready, 1'b0);
        cycle(1, make_line(0, 0, 41), 0);
        check("f3_rdy_l2", bus.ff_rd_ready, 1'b0);
        cycle(1, make_line(0, 1, 5), 0);
        check("f3_rdy_l3", bus.ff_rd_ready, 1'b1);
        check("f3_frames", frame_cnt, 1);
        drain();
        check("f3_empty", bus.ff_empty, 1'b1);
        check("f3_frames_end", frame_cnt, 0);

        // Pop while empty is ignored
        cycle(0, '0, 1);
        check("udf_fill", fill_level, 0);

        // Fill to DEPTH, then simultaneous pop and write while full
        for (int i = 0; i < DEPTH; i++) cycle(1, make_line(1, 1, $urandom_range(1, MAX_SYM)), 0);
        check("full_wr_ready", bus.wr_ready, 1'b0);
        check("full_fill", fill_level, DEPTH);
        cycle(1, make_line(1, 1, 7), 1);
        check("full_refused", last_acc, 1'b0);
        check("full_fill_after", fill_level, DEPTH - 1);
        check("full_wr_ready_after", bus.wr_ready, 1'b1);
        drain();

        // EOF in and EOF out together with two frames buffered
        cycle(1, make_line(1, 1, 3), 0);
        cycle(1, make_line(1, 1, 4), 0);
        check("eof2_before", frame_cnt, 2);
        cycle(1, make_line(1, 1, 9), 1);
        check("eof2_both", frame_cnt, 2);
        drain();

        // Pointer wrap: 200 single-line frames with random write/read gaps
        sent = 0;
        budget = 0;
        while ((sent < 200 || q.size() != 0) && budget < 4000) begin
            cycle(sent < 200 && $urandom_range(0, 3) != 0,
                  make_line(1, 1, $urandom_range(1, MAX_SYM)),
                  $urandom_range(0, 2) == 0);
            if (last_acc) sent++;
            check("wrap_fill_max", fill_level <= DEPTH, 1'b1);
            budget++;
        end
        check("wrap_sent", sent, 200);
        check("wrap_drained", bus.ff_empty, 1'b1);

        // Malformed heads: zero length, then SOF inside an open frame
        cycle(1, make_line(1, 1, 0), 0);
        cycle(1, make_line(1, 0, 5), 0);
        cycle(1, make_line(1, 1, 5), 0);
        drain();
`ifdef CL_FRAME_BUF_CHECK_EN
        check("chk_err_len", err_len, 1'b1);
        check("chk_err_seq", err_seq, 1'b1);
        check("chk_err_udf", err_udf, 1'b1);
`endif

        // Reset with ten lines stored, the last one an unfinished frame
        for (int i = 0; i < 9; i++) cycle(1, make_line(1, 1, 12), 0);
        cycle(1, make_line(1, 0, 12), 0);
        check("pre_rst_fill", fill_level, 10);
        rst_n = 0;
        #1;
        q.delete();
        ready_en = 0;
        exp_len = 0; exp_seq = 0; exp_ovf = 0; exp_udf = 0;
        m_open = 0; m_lines = 0;
        check_outputs();
        check("rst_fill", fill_level, 0);
        check("rst_rd_ready", bus.ff_rd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1;
        cycle(0, '0, 0);
        check("rst_wr_ready_back", bus.wr_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cl_frame_buffer.md
# cl_frame_buffer

Cache-line frame buffer sitting directly upstream of the CL-to-stream converter (CL2st_preAFU). Accepts 512-bit cache lines from the host write path, stores them in a show-ahead FIFO, and tracks how many complete frames are buffered. It raises `ff_rd_ready` once at least one whole frame is stored. The converter then drains lines with `ff_rdreq` and reads them on `ff_q`.

## Interface
Parameters:
- `CL`, 512, cache-line width
- `CL_HEAD`, 16, head field width, CL[15:0]
- `w_len_CLHead`, 10, width of length field, head[9:0]
- `DEPTH`, 64, FIFO depth in lines (power of two)
- `AW`, 6, log2(DEPTH)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous reset, active low
- `wr_valid`  in  1  host line valid
- `wr_ready`  out  1  buffer can accept a line
- `wr_data`  in  CL  host cache line
- `ff_rd_ready`  out  1  at least one complete frame buffered
- `ff_rdreq`  in  1  pop head line
- `ff_q`  out  CL  head line (show-ahead)
- `ff_empty`  out  1  FIFO empty
- `fill_level`  out  AW+1  lines stored
- `frame_cnt`  out  AW+1  complete frames stored
- `err_len`, `err_seq`, `err_ovf`, `err_udf`  out  1 each  sticky error flags (see Configuration)

## Operation
- Head format, fixed:
  - head[9:0] = number of valid 12-bit symbols in the payload, legal range 1..41.
  - head[14] = SOF (first line of frame).
  - head[15] = EOF (last line of frame).
  - head[13:10] reserved, zero.
  - A one-line frame has SOF=EOF=1.
- Write: accept when `wr_valid & wr_ready`; line written at `wr_ptr`, `wr_ptr` increments modulo DEPTH.
- Read: `ff_rdreq & !ff_empty` advances `rd_ptr` modulo DEPTH.
  - `ff_rdreq` while empty is ignored; pointers unchanged.
- `fill_level`: +1 on accepted write, −1 on effective read, unchanged when both occur in the same cycle.
- `frame_cnt`: +1 on accepted write with EOF=1, −1 on effective read of a line with EOF=1; both together leaves it unchanged.
- `ff_rd_ready = (frame_cnt != 0)`.
- A frame must not exceed DEPTH lines. Larger frames deadlock by design, flagged by `err_ovf` when checking is enabled.

## Timing
- Reset: pointers 0, `fill_level` 0, `frame_cnt` 0, `ff_empty` 1, `ff_rd_ready` 0, all `err_*` 0.
  - `wr_ready` is 1 one cycle after reset deassertion. It is held 0 while `rst_n` is low.
- `wr_ready = (fill_level != DEPTH)`, combinational from registered count. No combinational path from `wr_valid`.
- Latency:
  - A written line appears on `ff_q` and `ff_empty` falls the cycle after acceptance.
  - `ff_rd_ready` rises the cycle after the EOF line is accepted.
- `ff_q` is valid whenever `ff_empty` = 0 and changes the cycle after an effective pop.
- Full with simultaneous read and write: the write is refused because `wr_ready` = 0. The read proceeds, and `wr_ready` rises next cycle.
- Reset asserted mid-frame: all buffered lines are discarded immediately. Partial frames are lost.

## Configuration
- `CL_FRAME_BUF_CHECK_EN` defined: head checker compiled in. Flags stay set until reset.
  - `err_len` sets on an accepted line with length 0 or >41.
  - `err_seq` sets on SOF while a frame is open, or a non-SOF line while no frame is open.
  - `err_ovf` sets when the open frame's line count reaches DEPTH without EOF.
  - `err_udf` sets on `ff_rdreq` while empty.
  - Flags are informational only; data flow is unaffected.
- Undefined: checker absent, all `err_*` tied 0, and head fields other than EOF are ignored.

## Structure
- Shared package `cl_pkg`: CL, CL_HEAD, CL_PAYLOAD=496, ST=12, w_len_CLHead, head bit positions (SOF_BIT=14, EOF_BIT=15), MAX_SYM=41.
- One sub-module `cl_sync_fifo` (show-ahead, DEPTH×CL memory, pointers, fill count). Frame counting and the checker live in the top.

## Test plan
- Write 3-line frame (SOF/-/EOF, lengths 41,41,5) -> `ff_rd_ready` 0 until 1 cycle after 3rd accept, `frame_cnt`=1; pop 3 -> `frame_cnt`=0, `ff_empty`=1, data matches.
- Fill 64 lines without reads -> `wr_ready`=0 at `fill_level`=64. Then simultaneous pop and write -> write refused, `fill_level` 63, `wr_ready`=1 next cycle.
- EOF line written and EOF line popped in the same cycle with `frame_cnt`=2 -> `frame_cnt` stays 2.
- Pointer wrap: stream 200 single-line frames with random read gaps -> in-order data, no loss, `fill_level` never >64.
- Check enabled: length 0 line -> `err_len`=1. SOF inside open frame -> `err_seq`=1. Pop when empty -> `err_udf`=1 and pointers unchanged.
- Assert `rst_n`=0 with 10 lines stored -> next cycle `fill_level` 0, `ff_empty` 1, `ff_rd_ready` 0, errors cleared.
